// File: rtl/key_event_bank_if.sv
// Key bank bus: raw pins and repeat enables in, per-key pulses and the event code out.
// Latency: wiring only. Backpressure: none, every output is a fire-and-forget pulse or level.
// Ports: key_in/repeat_en (driver -> bank), key_level/press/release/long/repeat, evt_valid/evt_code (bank -> consumer).
interface key_event_bank_if #(
  parameter int NUM_KEYS = 5
);
  localparam int CODE_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] repeat_en;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_repeat;
  logic                evt_valid;
  logic [CODE_W-1:0]   evt_code;

  // master: the side that owns the pins and consumes the events
  modport master (
    output key_in, repeat_en,
    input  key_level, key_press, key_release, key_long, key_repeat, evt_valid, evt_code
  );

  // slave: the key bank itself
  modport slave (
    input  key_in, repeat_en,
    output key_level, key_press, key_release, key_long, key_repeat, evt_valid, evt_code
  );
endinterface

// File: rtl/key_event_bank.sv
// Multi-channel key front end: sync, debounce, press/release, long-press, auto-repeat, priority event.
// Latency: pin change -> key_level/key_press after 2 + DEBOUNCE_CYC edges; key_long HOLD_CYC after key_press.
// Backpressure: none; all outputs are registered 1-cycle pulses (or the debounced level) with no stall path.
// Ports: sys_clk, sys_rst_n (async active-low), bus (key_event_bank_if.slave).
module key_event_bank #(
  parameter int NUM_KEYS     = 5,
  parameter int DEBOUNCE_CYC = 200000,
  parameter int HOLD_CYC     = 5000000,
  parameter int REPEAT_CYC   = 1000000,
  parameter bit KEY_ACTIVE   = 1'b0
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  key_event_bank_if.slave bus
);

  localparam int CODE_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int PH_W   = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYC);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYC - 1);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(REPEAT_CYC - 1);

  // Synchroniser flops hold raw pin levels; reset value is the released level.
  localparam logic [NUM_KEYS-1:0] PIN_RELEASED = {NUM_KEYS{~KEY_ACTIVE}};

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] level_q;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] release_q;
  logic [NUM_KEYS-1:0] long_q;
  logic [NUM_KEYS-1:0] repeat_q;
  logic                evt_valid_q;
  logic [CODE_W-1:0]   evt_code_q;

  logic [DB_W-1:0]   db_cnt_q   [NUM_KEYS];
  logic [DB_W-1:0]   db_cnt_d   [NUM_KEYS];
  logic [HOLD_W-1:0] hold_cnt_q [NUM_KEYS];
  logic [HOLD_W-1:0] hold_cnt_d [NUM_KEYS];
  logic [PH_W-1:0]   phase_q    [NUM_KEYS];
  logic [PH_W-1:0]   phase_d    [NUM_KEYS];

  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] level_d;
  logic [NUM_KEYS-1:0] long_d;
  logic [NUM_KEYS-1:0] wrap_d;
  logic [NUM_KEYS-1:0] repeat_d;
  logic [NUM_KEYS-1:0] evt_vec;
  logic [CODE_W-1:0]   code_d;

  always_comb begin
    pressed  = KEY_ACTIVE ? sync2_q : ~sync2_q;
    level_d  = level_q;
    long_d   = '0;
    wrap_d   = '0;
    repeat_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_cnt_d[i]   = db_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      phase_d[i]    = phase_q[i];

      // Debounce: count only while the synced pin disagrees with the accepted level.
      // The toggle happens on the edge after the counter has sat at DEBOUNCE_CYC,
      // giving the 2 + DEBOUNCE_CYC edge latency from pin to level.
      if (pressed[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_MAX) begin
        level_d[i]  = ~level_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end

      // Hold/phase run only while the key stays down across this edge; using the
      // next level means a release edge already suppresses long/repeat.
      if (level_q[i] && level_d[i]) begin
        if (hold_cnt_q[i] != HOLD_MAX) begin
          hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
          long_d[i]     = (hold_cnt_q[i] == HOLD_PRE);
        end else begin
          // Phase starts at 0 on the long-press edge and free-runs mod REPEAT_CYC;
          // repeat_en never touches it, so re-enabling resumes on a phase boundary.
          wrap_d[i]  = (phase_q[i] == PH_LAST);
          phase_d[i] = wrap_d[i] ? '0 : phase_q[i] + 1'b1;
        end
      end else begin
        hold_cnt_d[i] = '0;
        phase_d[i]    = '0;
      end

      repeat_d[i] = bus.repeat_en[i] & (long_d[i] | wrap_d[i]);
    end

    // Lowest index wins; other simultaneous events stay visible only per key.
    evt_vec = (level_d & ~level_q) | repeat_d;
    code_d  = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (evt_vec[i]) code_d = CODE_W'(i);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q     <= PIN_RELEASED;
      sync2_q     <= PIN_RELEASED;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      repeat_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
        phase_q[i]    <= '0;
      end
    end else begin
      sync1_q     <= bus.key_in;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      press_q     <= level_d & ~level_q;
      release_q   <= ~level_d & level_q;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      evt_valid_q <= |evt_vec;
      evt_code_q  <= code_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        phase_q[i]    <= phase_d[i];
      end
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.key_long    = long_q;
  assign bus.key_repeat  = repeat_q;
  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_code    = evt_code_q;

endmodule

// File: tb/tb_key_event_bank.sv
// Bench for key_event_bank: directed scenarios plus randomized pin activity against a behavioural model.
// Latency: model predicts each edge's outputs; compared on the following falling edge.
// Backpressure: none.
module tb_key_event_bank;

  localparam int N = 5;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   checks;
  int   errors;

  key_event_bank_if #(.NUM_KEYS(N)) bus ();

  key_event_bank #(
    .NUM_KEYS(N), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R), .KEY_ACTIVE(1'b0)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A level is accepted once the pressed/released pin reading has been the
  // opposite value for D+1 consecutive samples ending two edges ago.
  // Long press and repeats are fixed offsets from the press edge.
  bit [D+2:0]   hist [N];
  bit [N-1:0]   m_lvl;
  int           press_edge [N];
  int           m_cyc;
  int           m_age;
  bit           m_flip;
  bit           m_nl;
  logic [N-1:0] exp_level, exp_press, exp_rel, exp_long, exp_rep;
  logic         exp_vld;
  int           exp_code;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        hist[k]       = '0;
        press_edge[k] = 0;
      end
      m_lvl     = '0;
      exp_level = '0;
      exp_press = '0;
      exp_rel   = '0;
      exp_long  = '0;
      exp_rep   = '0;
      exp_vld   = 1'b0;
      exp_code  = 0;
    end else begin
      m_cyc++;
      for (int k = 0; k < N; k++) begin
        hist[k] = {hist[k][D+1:0], (bus.key_in[k] == 1'b0)};
        m_flip = 1'b1;
        for (int j = 2; j <= D + 2; j++) begin
          if (hist[k][j] == m_lvl[k]) m_flip = 1'b0;
        end
        m_nl = m_flip ? ~m_lvl[k] : m_lvl[k];
        exp_press[k] = m_nl & ~m_lvl[k];
        exp_rel[k]   = ~m_nl & m_lvl[k];
        if (exp_press[k]) press_edge[k] = m_cyc;
        m_age = m_cyc - press_edge[k];
        exp_long[k] = m_nl && m_lvl[k] && (m_age == H);
        exp_rep[k]  = m_nl && m_lvl[k] && (m_age >= H) && (((m_age - H) % R) == 0)
                      && bus.repeat_en[k];
        m_lvl[k] = m_nl;
      end
      exp_level = m_lvl;
      exp_vld   = |(exp_press | exp_rep);
      exp_code  = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (exp_press[k] || exp_rep[k]) exp_code = k;
      end
    end
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_level",   8'(bus.key_level),   8'(exp_level));
      cmp("m_press",   8'(bus.key_press),   8'(exp_press));
      cmp("m_release", 8'(bus.key_release), 8'(exp_rel));
      cmp("m_long",    8'(bus.key_long),    8'(exp_long));
      cmp("m_repeat",  8'(bus.key_repeat),  8'(exp_rep));
      cmp("m_evt_vld", 8'(bus.evt_valid),   8'(exp_vld));
      if (exp_vld) cmp("m_evt_code", 8'(bus.evt_code), 8'(exp_code));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int mode;

  initial begin
    rst_n         = 1'b0;
    bus.key_in    = '1;
    bus.repeat_en = '0;
    chk_en        = 1'b1;
    checks        = 0;
    errors        = 0;

    // Reset state
    step(3);
    cmp("rst_level", 8'(bus.key_level), 8'h00);
    cmp("rst_press", 8'(bus.key_press), 8'h00);
    cmp("rst_evt",   8'(bus.evt_valid), 8'h00);
    rst_n = 1'b1;
    step(10);

    // Clean press/release on key 2: pin low before edge 0, press at edge 6
    bus.key_in[2] = 1'b0;
    step(6);
    cmp("press2_early", 8'(bus.key_press), 8'h00);
    step(1);
    cmp("press2",      8'(bus.key_press), 8'b00100);
    cmp("level2",      8'(bus.key_level), 8'b00100);
    cmp("press2_vld",  8'(bus.evt_valid), 8'h01);
    cmp("press2_code", 8'(bus.evt_code),  8'h02);
    step(23);
    bus.key_in[2] = 1'b1;            // sampled at edge 30
    step(6);
    cmp("rel2_early", 8'(bus.key_release), 8'h00);
    step(1);
    cmp("rel2",       8'(bus.key_release), 8'b00100);
    cmp("rel2_level", 8'(bus.key_level),   8'h00);
    step(2);
    cmp("rel2_nolong", 8'(bus.key_long), 8'h00);
    step(10);

    // Bounce rejection on key 0
    bus.key_in[0] = 1'b0; step(3);
    bus.key_in[0] = 1'b1; step(1);
    bus.key_in[0] = 1'b0; step(3);
    bus.key_in[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      cmp("bounce_level", 8'(bus.key_level[0]), 8'h00);
    end
    bus.key_in[0] = 1'b0;
    step(6);
    cmp("bounce_press_early", 8'(bus.key_press), 8'h00);
    step(1);
    cmp("bounce_press", 8'(bus.key_press), 8'b00001);
    step(3);
    bus.key_in[0] = 1'b1;
    step(12);

    // Long press with repeats on key 4
    bus.repeat_en[4] = 1'b1;
    bus.key_in[4]    = 1'b0;
    step(7);
    cmp("hold_press", 8'(bus.key_press), 8'b10000);
    step(19);
    cmp("hold_long_early", 8'(bus.key_long), 8'h00);
    step(1);
    cmp("hold_long",   8'(bus.key_long),   8'b10000);
    cmp("hold_rep0",   8'(bus.key_repeat), 8'b10000);
    cmp("hold_vld",    8'(bus.evt_valid),  8'h01);
    cmp("hold_code",   8'(bus.evt_code),   8'h04);
    for (int n = 1; n <= 3; n++) begin
      step(4);
      cmp("hold_rep_gap", 8'(bus.key_repeat), 8'h00);
      step(1);
      cmp("hold_rep_n",  8'(bus.key_repeat), 8'b10000);
      cmp("hold_rep_cd", 8'(bus.evt_code),   8'h04);
    end
    bus.key_in[4] = 1'b1;
    step(12);

    // repeat_en toggled mid-hold
    bus.key_in[4] = 1'b0;
    step(7);                         // press edge P
    step(20);
    cmp("tog_long", 8'(bus.key_long), 8'b10000);
    step(5);
    cmp("tog_rep25", 8'(bus.key_repeat), 8'b10000);
    step(1);
    bus.repeat_en[4] = 1'b0;         // sampled at P+27
    step(4);
    cmp("tog_rep30_off", 8'(bus.key_repeat), 8'h00);
    step(1);
    bus.repeat_en[4] = 1'b1;         // sampled at P+32
    step(1);
    cmp("tog_rep32_none", 8'(bus.key_repeat), 8'h00);
    step(3);
    cmp("tog_rep35", 8'(bus.key_repeat), 8'b10000);
    bus.key_in[4] = 1'b1;
    step(12);

    // Long press with repeat disabled
    bus.repeat_en[4] = 1'b0;
    bus.key_in[4]    = 1'b0;
    step(27);
    cmp("norep_long", 8'(bus.key_long),   8'b10000);
    cmp("norep_rep",  8'(bus.key_repeat), 8'h00);
    cmp("norep_vld",  8'(bus.evt_valid),  8'h00);
    step(5);
    cmp("norep_vld25", 8'(bus.evt_valid), 8'h00);
    bus.key_in[4] = 1'b1;
    step(12);

    // Simultaneous press on keys 1 and 3
    bus.key_in[1] = 1'b0;
    bus.key_in[3] = 1'b0;
    step(7);
    cmp("sim_press", 8'(bus.key_press), 8'b01010);
    cmp("sim_level", 8'(bus.key_level), 8'b01010);
    cmp("sim_vld",   8'(bus.evt_valid), 8'h01);
    cmp("sim_code",  8'(bus.evt_code),  8'h01);
    step(1);
    cmp("sim_vld_once", 8'(bus.evt_valid), 8'h00);
    bus.key_in[1] = 1'b1;
    bus.key_in[3] = 1'b1;
    step(12);

    // Reset mid-hold on key 2
    bus.key_in[2] = 1'b0;
    step(7);
    cmp("rh_press", 8'(bus.key_press), 8'b00100);
    step(22);
    #2 rst_n = 1'b0;
    #1;
    cmp("rh_level", 8'(bus.key_level),  8'h00);
    cmp("rh_long",  8'(bus.key_long),   8'h00);
    cmp("rh_evt",   8'(bus.evt_valid),  8'h00);
    step(3);
    rst_n = 1'b1;
    step(6);
    cmp("rh_press_early", 8'(bus.key_press), 8'h00);
    step(1);
    cmp("rh_press_again", 8'(bus.key_press), 8'b00100);
    step(19);
    cmp("rh_long_early", 8'(bus.key_long), 8'h00);
    step(1);
    cmp("rh_long_again", 8'(bus.key_long), 8'b00100);
    bus.key_in[2] = 1'b1;
    step(12);

    // Randomized activity: quiet, bouncy and medium phases, plus one async reset
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) mode = $urandom_range(0, 2);
      for (int k = 0; k < N; k++) begin
        case (mode)
          0:       if ($urandom_range(0, 119) == 0) bus.key_in[k] = ~bus.key_in[k];
          1:       if ($urandom_range(0, 2) == 0)   bus.key_in[k] = ~bus.key_in[k];
          default: if ($urandom_range(0, 14) == 0)  bus.key_in[k] = ~bus.key_in[k];
        endcase
        if ($urandom_range(0, 39) == 0) bus.repeat_en[k] = ~bus.repeat_en[k];
      end
      if (c == 2000) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    step(10);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
